// File: rtl/inst_rom_ctrl.sv
// Instruction store with a boot-load stream port and a wait-stated fetch handshake.
// Fetches at or beyond the loaded image return NOP_WORD and raise addr_err_o.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | accepting fetches; load_mode_i starts a new image
//   S_LOAD  | streaming load words into the store until load_mode_i falls
//   S_WAIT  | fetch accepted, counting down wait states
//   S_RESP  | one-cycle instr_valid_o pulse with the fetched word
module inst_rom_ctrl #(
   parameter int                    DATA_WIDTH  = 8,
   parameter int                    ADDR_WIDTH  = 8,
   parameter int                    DEPTH       = 256,
   parameter int                    WAIT_STATES = 1,
   parameter logic [DATA_WIDTH-1:0] NOP_WORD    = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  load_mode_i,
   input  logic                  load_valid_i,
   input  logic [DATA_WIDTH-1:0] load_data_i,
   output logic                  load_ready_o,
   output logic [ADDR_WIDTH:0]   load_count_o,
   input  logic                  fetch_req_i,
   input  logic [ADDR_WIDTH-1:0] fetch_addr_i,
   output logic                  fetch_ready_o,
   output logic                  instr_valid_o,
   output logic [DATA_WIDTH-1:0] instructor_o,
   output logic                  addr_err_o
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LOAD = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_RESP = 2'd3;

   localparam int              CW      = ADDR_WIDTH + 1;
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [3:0]      WS_C    = 4'(WAIT_STATES);

   logic [1:0]            state_q, state_d;
   logic [3:0]            cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [DATA_WIDTH-1:0] instr_q, instr_d;
   logic                  err_q, err_d;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic                  wr_en;
   logic                  rd_err;
   logic [DATA_WIDTH-1:0] rd_word;

   // load_count doubles as the write pointer; it never passes DEPTH, so no wrap
   assign wr_en   = (state_q == S_LOAD) && load_valid_i && (count_q < DEPTH_C);
   assign rd_err  = ({1'b0, addr_q} >= count_q) || ({1'b0, addr_q} >= DEPTH_C);
   assign rd_word = rd_err ? NOP_WORD : mem_q[addr_q];

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      count_d = count_q;
      instr_d = instr_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (load_mode_i) begin
               state_d = S_LOAD;
               count_d = '0;
            end else if (fetch_req_i) begin
               state_d = S_WAIT;
               addr_d  = fetch_addr_i;
               cnt_d   = WS_C;
            end
         end
         S_LOAD: begin
            if (wr_en) count_d = count_q + 1'b1;
            if (!load_mode_i) state_d = S_IDLE;
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               instr_d = rd_word;
               err_d   = rd_err;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         count_q <= '0;
         instr_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         instr_q <= instr_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (wr_en) begin
         mem_q[count_q[ADDR_WIDTH-1:0]] <= load_data_i;
      end
   end

   // state_q sits at S_IDLE during reset, so fetch_ready needs the reset gate
   assign fetch_ready_o = rst_n_i && (state_q == S_IDLE) && !load_mode_i;
   assign load_ready_o  = (state_q == S_LOAD) && (count_q < DEPTH_C);
   assign instr_valid_o = (state_q == S_RESP);
   assign instructor_o  = instr_q;
   assign addr_err_o    = err_q;
   assign load_count_o  = count_q;

endmodule

// File: tb/tb_inst_rom_ctrl.sv
// Directed bench for inst_rom_ctrl: instance 0 uses WAIT_STATES=1, instances 1/2 use 0/3.
// All three share inputs; the 0/3 instances are only checked straight after reset.
module tb_inst_rom_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load_mode, load_valid, fetch_req;
   logic [7:0] load_data, fetch_addr;

   logic [2:0] ld_rdy, fr, iv, err;
   logic [8:0] lc  [3];
   logic [7:0] ins [3];

   int checks = 0;
   int errors = 0;

   logic [7:0] img [$];
   logic       rdy_log [300];

   typedef struct {
      logic [7:0] addr;
      logic [7:0] exp_ins;
      logic       exp_err;
   } vec_t;
   vec_t vecs [7];

   always #5 clk = ~clk;

   inst_rom_ctrl #(.WAIT_STATES(1)) u_ws1 (
      .clk_i(clk), .rst_n_i(rst_n), .load_mode_i(load_mode), .load_valid_i(load_valid),
      .load_data_i(load_data), .load_ready_o(ld_rdy[0]), .load_count_o(lc[0]),
      .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_ready_o(fr[0]),
      .instr_valid_o(iv[0]), .instructor_o(ins[0]), .addr_err_o(err[0]));

   inst_rom_ctrl #(.WAIT_STATES(0)) u_ws0 (
      .clk_i(clk), .rst_n_i(rst_n), .load_mode_i(load_mode), .load_valid_i(load_valid),
      .load_data_i(load_data), .load_ready_o(ld_rdy[1]), .load_count_o(lc[1]),
      .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_ready_o(fr[1]),
      .instr_valid_o(iv[1]), .instructor_o(ins[1]), .addr_err_o(err[1]));

   inst_rom_ctrl #(.WAIT_STATES(3)) u_ws3 (
      .clk_i(clk), .rst_n_i(rst_n), .load_mode_i(load_mode), .load_valid_i(load_valid),
      .load_data_i(load_data), .load_ready_o(ld_rdy[2]), .load_count_o(lc[2]),
      .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_ready_o(fr[2]),
      .instr_valid_o(iv[2]), .instructor_o(ins[2]), .addr_err_o(err[2]));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Fetch on instance 0: waits for fetch_ready, returns word, error flag and
   // cycles from the accepting edge to the instr_valid cycle (-1 on timeout).
   task automatic do_fetch(input logic [7:0] a, output logic [7:0] w, output logic e,
                           output int lat);
      int tries;
      w   = 8'h00;
      e   = 1'b0;
      lat = -1;
      tries = 0;
      while (!fr[0] && tries < 20) begin
         step();
         tries++;
      end
      chk("fetch_ready_wait", {31'd0, fr[0]}, 32'd1);
      fetch_req  = 1'b1;
      fetch_addr = a;
      step();
      fetch_req  = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if (iv[0]) begin
            lat = k;
            w   = ins[0];
            e   = err[0];
            break;
         end
         step();
      end
   endtask

   task automatic load_img(input bit drop_with_last);
      load_mode = 1'b1;
      step();
      for (int i = 0; i < img.size(); i++) begin
         load_valid = 1'b1;
         load_data  = img[i];
         if (drop_with_last && i == img.size() - 1) load_mode = 1'b0;
         rdy_log[i] = ld_rdy[0];
         step();
      end
      load_valid = 1'b0;
      load_mode  = 1'b0;
      step();
   endtask

   initial begin
      logic [7:0] w;
      logic       e;
      int         lat;
      int         first [3];
      bit         fr_bad [3];
      bit         saw;
      int         nrdy;

      vecs[0] = '{8'd0,   8'hA5, 1'b0};
      vecs[1] = '{8'd1,   8'h3C, 1'b0};
      vecs[2] = '{8'd2,   8'h7E, 1'b0};
      vecs[3] = '{8'd3,   8'h01, 1'b0};
      vecs[4] = '{8'd4,   8'h00, 1'b1};
      vecs[5] = '{8'd5,   8'h00, 1'b1};
      vecs[6] = '{8'd255, 8'h00, 1'b1};

      rst_n = 1'b0; load_mode = 1'b0; load_valid = 1'b0; fetch_req = 1'b0;
      load_data = 8'h00; fetch_addr = 8'h00;
      repeat (3) step();
      for (int j = 0; j < 3; j++) begin
         chk("rst_instr_valid", {31'd0, iv[j]}, 32'd0);
         chk("rst_instructor",  {24'd0, ins[j]}, 32'd0);
         chk("rst_addr_err",    {31'd0, err[j]}, 32'd0);
         chk("rst_load_count",  {23'd0, lc[j]}, 32'd0);
         chk("rst_load_ready",  {31'd0, ld_rdy[j]}, 32'd0);
         chk("rst_fetch_ready", {31'd0, fr[j]}, 32'd0);
      end
      rst_n = 1'b1;
      step();

      // Back-to-back fetch of addr 0 on an empty image, all three wait-state settings
      fetch_req = 1'b1; fetch_addr = 8'h00;
      step();
      for (int j = 0; j < 3; j++) begin first[j] = -1; fr_bad[j] = 1'b0; end
      for (int k = 0; k < 6; k++) begin
         for (int j = 0; j < 3; j++) begin
            if (first[j] < 0) begin
               if (iv[j]) begin
                  first[j] = k;
                  chk("empty_instructor", {24'd0, ins[j]}, 32'h00);
                  chk("empty_addr_err",   {31'd0, err[j]}, 32'd1);
               end else if (fr[j]) begin
                  fr_bad[j] = 1'b1;
               end
            end
         end
         step();
      end
      fetch_req = 1'b0;
      chk("latency_ws1", first[0], 32'd2);
      chk("latency_ws0", first[1], 32'd1);
      chk("latency_ws3", first[2], 32'd4);
      for (int j = 0; j < 3; j++) chk("fetch_ready_low_inflight", {31'd0, fr_bad[j]}, 32'd0);
      repeat (10) step();

      // Four-word image, last word offered in the cycle load_mode falls
      img = '{8'hA5, 8'h3C, 8'h7E, 8'h01};
      load_img(1'b1);
      chk("load_count_4", {23'd0, lc[0]}, 32'd4);
      for (int i = 0; i < 4; i++) chk("load_ready_in_load", {31'd0, rdy_log[i]}, 32'd1);
      chk("load_ready_idle", {31'd0, ld_rdy[0]}, 32'd0);

      for (int i = 0; i < 7; i++) begin
         do_fetch(vecs[i].addr, w, e, lat);
         chk("vec_latency",    lat, 32'd2);
         chk("vec_instructor", {24'd0, w}, {24'd0, vecs[i].exp_ins});
         chk("vec_addr_err",   {31'd0, e}, {31'd0, vecs[i].exp_err});
      end

      do_fetch(8'd2, w, e, lat);
      chk("hold_first", {24'd0, w}, 32'h7E);
      step();
      chk("hold_valid_low",  {31'd0, iv[0]}, 32'd0);
      chk("hold_instructor", {24'd0, ins[0]}, 32'h7E);

      // load_mode raised while a fetch is waiting
      while (!fr[0]) step();
      fetch_req = 1'b1; fetch_addr = 8'd1;
      step();
      fetch_req = 1'b0; load_mode = 1'b1;
      chk("wait_load_ready", {31'd0, ld_rdy[0]}, 32'd0);
      lat = -1;
      for (int k = 0; k < 10; k++) begin
         if (iv[0]) begin
            lat = k;
            chk("wait_load_instr", {24'd0, ins[0]}, 32'h3C);
            chk("wait_load_err",   {31'd0, err[0]}, 32'd0);
            break;
         end
         step();
      end
      chk("wait_load_latency", lat, 32'd2);
      lat = -1;
      for (int k = 0; k < 10; k++) begin
         if (ld_rdy[0]) begin lat = k; break; end
         step();
      end
      chk("wait_load_entered", {31'd0, ld_rdy[0]}, 32'd1);
      chk("wait_load_count0",  {23'd0, lc[0]}, 32'd0);
      load_mode = 1'b0;
      step();

      // Overflow: DEPTH+2 words
      img.delete();
      for (int i = 0; i < 256; i++) img.push_back(8'(i) ^ 8'h5A);
      img.push_back(8'hEE);
      img.push_back(8'hFF);
      load_img(1'b0);
      nrdy = 0;
      for (int i = 0; i < 256; i++) if (rdy_log[i]) nrdy++;
      chk("ovf_ready_first256", nrdy, 32'd256);
      chk("ovf_ready_257",      {31'd0, rdy_log[256]}, 32'd0);
      chk("ovf_ready_258",      {31'd0, rdy_log[257]}, 32'd0);
      chk("ovf_load_count",     {23'd0, lc[0]}, 32'd256);
      do_fetch(8'd0, w, e, lat);
      chk("ovf_mem0", {24'd0, w}, 32'h5A);
      chk("ovf_err0", {31'd0, e}, 32'd0);
      do_fetch(8'd255, w, e, lat);
      chk("ovf_mem255", {24'd0, w}, 32'hA5);
      chk("ovf_err255", {31'd0, e}, 32'd0);

      // Reset in the middle of WAIT
      while (!fr[0]) step();
      fetch_req = 1'b1; fetch_addr = 8'd3;
      step();
      fetch_req = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("midrst_valid",       {31'd0, iv[0]}, 32'd0);
      chk("midrst_fetch_ready", {31'd0, fr[0]}, 32'd0);
      chk("midrst_instructor",  {24'd0, ins[0]}, 32'd0);
      chk("midrst_load_count",  {23'd0, lc[0]}, 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      saw = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (iv[0]) saw = 1'b1;
         step();
      end
      chk("midrst_no_pulse",   {31'd0, saw}, 32'd0);
      chk("midrst_rel_instr",  {24'd0, ins[0]}, 32'd0);
      chk("midrst_rel_err",    {31'd0, err[0]}, 32'd0);
      chk("midrst_rel_count",  {23'd0, lc[0]}, 32'd0);
      chk("midrst_rel_ldrdy",  {31'd0, ld_rdy[0]}, 32'd0);
      do_fetch(8'd0, w, e, lat);
      chk("midrst_cleared_word", {24'd0, w}, 32'h00);
      chk("midrst_cleared_err",  {31'd0, e}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
